// File: rtl/dut_seq_if.sv
// ============================================================================
// Module   : dut_seq_if
// Brief    : Pops encoded requests from a show-ahead stimulus FIFO, drives
//            mosi / target_sel, waits settle or idle intervals, samples miso
//            and pushes results under back-pressure.
//            Optional macro DUT_SEQ_IF_MISO_SYNC_EN adds a 2-flop miso synchroniser.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dut_seq_if #(
   parameter int STF_WIDTH  = 24,
   parameter int RTF_WIDTH  = 24,
   parameter int REQ_WIDTH  = 3,
   parameter int CMD_WIDTH  = 5,
   parameter int WAIT_WIDTH = 16,
   parameter int DSEL_WIDTH = 5
) (
   input  logic                                     clock,
   input  logic                                     reset_n,
   input  logic                                     enable,
   output logic                                     done,
   output logic                                     error,
   input  logic [REQ_WIDTH+CMD_WIDTH+STF_WIDTH-1:0] sfifo_data,
   output logic                                     sfifo_rdreq,
   input  logic                                     sfifo_rdempty,
   output logic [RTF_WIDTH-1:0]                     rfifo_data,
   output logic                                     rfifo_wrreq,
   input  logic                                     rfifo_wrfull,
   output logic [DSEL_WIDTH-1:0]                    target_sel,
   output logic [STF_WIDTH-1:0]                     mosi,
   input  logic [RTF_WIDTH-1:0]                     miso
);

   localparam logic [REQ_WIDTH-1:0] c_OP_NOP      = REQ_WIDTH'(0);
   localparam logic [REQ_WIDTH-1:0] c_OP_DRIVE    = REQ_WIDTH'(1);
   localparam logic [REQ_WIDTH-1:0] c_OP_DRIVE_NS = REQ_WIDTH'(2);
   localparam logic [REQ_WIDTH-1:0] c_OP_WAIT     = REQ_WIDTH'(3);
   localparam logic [REQ_WIDTH-1:0] c_OP_SEL      = REQ_WIDTH'(4);
   localparam logic [REQ_WIDTH-1:0] c_OP_END      = REQ_WIDTH'(5);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_SETTLE = 3'd2,
      S_PUSH   = 3'd3,
      S_WAIT   = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t                  r_state;
   logic [WAIT_WIDTH-1:0]   r_count;
   logic                    r_done;
   logic                    r_error;
   logic [STF_WIDTH-1:0]    r_mosi;
   logic [DSEL_WIDTH-1:0]   r_sel;
   logic [RTF_WIDTH-1:0]    r_result;

   logic [REQ_WIDTH-1:0]    w_req;
   logic [CMD_WIDTH-1:0]    w_cmd;
   logic [STF_WIDTH-1:0]    w_payload;
   logic [RTF_WIDTH-1:0]    w_miso;

   assign {w_req, w_cmd, w_payload} = sfifo_data;

`ifdef DUT_SEQ_IF_MISO_SYNC_EN
   logic [RTF_WIDTH-1:0] r_miso_s1;
   logic [RTF_WIDTH-1:0] r_miso_s2;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_miso_s1 <= '0;
         r_miso_s2 <= '0;
      end else begin
         r_miso_s1 <= miso;
         r_miso_s2 <= r_miso_s1;
      end
   end

   assign w_miso = r_miso_s2;
`else
   assign w_miso = miso;
`endif

   // Pop and push are both gated by state, so they can never coincide.
   assign sfifo_rdreq = (r_state == S_FETCH) && !sfifo_rdempty;
   assign rfifo_wrreq = (r_state == S_PUSH)  && !rfifo_wrfull;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_count  <= '0;
         r_done   <= 1'b0;
         r_error  <= 1'b0;
         r_mosi   <= '0;
         r_sel    <= '0;
         r_result <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (enable) begin
                  r_error <= 1'b0;
                  r_state <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (!sfifo_rdempty) begin
                  case (w_req)
                     c_OP_NOP: ;
                     c_OP_DRIVE: begin
                        r_mosi  <= w_payload;
                        r_count <= WAIT_WIDTH'(w_cmd);
                        r_state <= S_SETTLE;
                     end
                     c_OP_DRIVE_NS: r_mosi <= w_payload;
                     c_OP_WAIT: begin
                        r_count <= w_payload[WAIT_WIDTH-1:0];
                        r_state <= S_WAIT;
                     end
                     c_OP_SEL: r_sel <= w_payload[DSEL_WIDTH-1:0];
                     c_OP_END: begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                     end
                     default: r_error <= 1'b1;
                  endcase
               end
            end
            S_SETTLE: begin
               if (r_count == '0) begin
                  r_result <= w_miso;
                  r_state  <= S_PUSH;
               end else begin
                  r_count <= r_count - WAIT_WIDTH'(1);
               end
            end
            S_PUSH: begin
               if (!rfifo_wrfull) begin
                  r_state <= S_FETCH;
               end
            end
            S_WAIT: begin
               if (r_count == '0) begin
                  r_state <= S_FETCH;
               end else begin
                  r_count <= r_count - WAIT_WIDTH'(1);
               end
            end
            S_DONE: begin
               if (!enable) begin
                  r_done  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign done       = r_done;
   assign error      = r_error;
   assign mosi       = r_mosi;
   assign target_sel = r_sel;
   assign rfifo_data = r_result;

endmodule

`default_nettype wire

// File: tb/tb_dut_seq_if.sv
// Directed bench for dut_seq_if: behavioural stimulus/result FIFOs around the
// sequencer, with hand-computed expectations checked by immediate assertions.
`default_nettype none

module tb_dut_seq_if;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        enable;
   logic        done;
   logic        error;
   logic [31:0] sfifo_data;
   logic        sfifo_rdreq;
   logic        sfifo_rdempty;
   logic [23:0] rfifo_data;
   logic        rfifo_wrreq;
   logic        rfifo_wrfull;
   logic [4:0]  target_sel;
   logic [23:0] mosi;
   logic [23:0] miso;

   logic [31:0] stim_mem [0:63];
   logic [23:0] res_mem  [0:15];
   int          pop_cyc  [0:63];
   int          wp = 0;
   int          rp = 0;
   int          res_cnt = 0;
   int          cyc = 0;
   int          drv_cyc = 0;
   logic        overlap = 1'b0;
   logic        step_mode = 1'b0;
   logic [23:0] miso_const = '0;

   int n_pass = 0;
   int n_total = 0;

   dut_seq_if dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .enable        (enable),
      .done          (done),
      .error         (error),
      .sfifo_data    (sfifo_data),
      .sfifo_rdreq   (sfifo_rdreq),
      .sfifo_rdempty (sfifo_rdempty),
      .rfifo_data    (rfifo_data),
      .rfifo_wrreq   (rfifo_wrreq),
      .rfifo_wrfull  (rfifo_wrfull),
      .target_sel    (target_sel),
      .mosi          (mosi),
      .miso          (miso)
   );

   initial forever #5 clock = ~clock;

   assign sfifo_rdempty = (rp == wp);
   assign sfifo_data    = stim_mem[rp[5:0]];
   assign miso          = step_mode ? 24'(32'h100000 + cyc) : miso_const;

   always @(posedge clock) begin
      if (sfifo_rdreq) begin
         pop_cyc[rp[5:0]] <= cyc;
         if (sfifo_data[31:29] == 3'd1) drv_cyc <= cyc;
         rp <= rp + 1;
      end
      if (rfifo_wrreq) begin
         res_mem[res_cnt[3:0]] <= rfifo_data;
         res_cnt <= res_cnt + 1;
      end
      if (sfifo_rdreq && rfifo_wrreq) overlap <= 1'b1;
      cyc <= cyc + 1;
   end

   function automatic logic [31:0] mk(input int req, input int cmd, input int payload);
      return {req[2:0], cmd[4:0], payload[23:0]};
   endfunction

   task automatic push(input logic [31:0] w);
      stim_mem[wp[5:0]] = w;
      wp++;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (done !== 1'b1 && n < 200) begin
         @(negedge clock);
         n++;
      end
      check(tag, 32'(done), 32'd1);
   endtask

   task automatic finish_run();
      enable = 1'b0;
      @(negedge clock);
      @(negedge clock);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      logic [23:0] exp_cap;
      reset_n      = 1'b0;
      enable       = 1'b0;
      rfifo_wrfull = 1'b0;
      repeat (2) @(negedge clock);

      check("rst_done",  32'(done),        32'd0);
      check("rst_error", 32'(error),       32'd0);
      check("rst_rdreq", 32'(sfifo_rdreq), 32'd0);
      check("rst_wrreq", 32'(rfifo_wrreq), 32'd0);
      check("rst_mosi",  32'(mosi),        32'd0);
      check("rst_sel",   32'(target_sel),  32'd0);
      check("rst_rdata", 32'(rfifo_data),  32'd0);
      reset_n = 1'b1;
      @(negedge clock);

      // Basic run: SEL 5, DRIVE cmd 0, END
      miso_const = 24'h123456;
      push(mk(4, 0, 5));
      push(mk(1, 0, 24'hA5A5A5));
      push(mk(5, 0, 0));
      enable = 1'b1;
      wait_done("t1_done");
      check("t1_sel",    32'(target_sel), 32'd5);
      check("t1_mosi",   32'(mosi),       32'hA5A5A5);
      check("t1_pushes", 32'(res_cnt),    32'd1);
      check("t1_result", 32'(res_mem[0]), 32'h123456);
      check("t1_error",  32'(error),      32'd0);
      finish_run();
      check("t1_done_clr", 32'(done), 32'd0);

      // DRIVE cmd 3 with miso stepping every cycle
      step_mode = 1'b1;
      push(mk(1, 3, 24'h0F0F0F));
      push(mk(5, 0, 0));
      enable = 1'b1;
      wait_done("t2_done");
`ifdef DUT_SEQ_IF_MISO_SYNC_EN
      exp_cap = 24'(32'h100000 + drv_cyc + 2);
`else
      exp_cap = 24'(32'h100000 + drv_cyc + 4);
`endif
      check("t2_pushes", 32'(res_cnt),    32'd2);
      check("t2_result", 32'(res_mem[1]), 32'(exp_cap));
      check("t2_mosi",   32'(mosi),       32'h0F0F0F);
      check("t2_sel",    32'(target_sel), 32'd5);
      finish_run();
      step_mode = 1'b0;

      // Back-pressure: result FIFO full while in PUSH
      miso_const   = 24'hABCDEF;
      rfifo_wrfull = 1'b1;
      base = wp;
      push(mk(1, 0, 24'h111111));
      push(mk(5, 0, 0));
      enable = 1'b1;
      repeat (13) @(negedge clock);
      check("t3_wrreq_full", 32'(rfifo_wrreq), 32'd0);
      check("t3_rdreq_full", 32'(sfifo_rdreq), 32'd0);
      check("t3_rdata_hold", 32'(rfifo_data),  32'hABCDEF);
      check("t3_no_push",    32'(res_cnt),     32'd2);
      check("t3_no_pop",     32'(rp),          32'(base + 1));
      rfifo_wrfull = 1'b0;
      #1;
      check("t3_wrreq_rise", 32'(rfifo_wrreq), 32'd1);
      wait_done("t3_done");
      check("t3_pushes", 32'(res_cnt),    32'd3);
      check("t3_result", 32'(res_mem[2]), 32'hABCDEF);
      finish_run();

      // WAIT 0 then WAIT 7: pop-to-pop gaps of 2 and 9 edges
      base = wp;
      push(mk(3, 0, 0));
      push(mk(3, 0, 7));
      push(mk(5, 0, 0));
      enable = 1'b1;
      wait_done("t4_done");
      check("t4_wait0_gap", 32'(pop_cyc[base + 1] - pop_cyc[base]),     32'd2);
      check("t4_wait7_gap", 32'(pop_cyc[base + 2] - pop_cyc[base + 1]), 32'd9);
      finish_run();

      // Unknown opcode sets sticky error; next start clears it
      push(mk(6, 0, 0));
      push(mk(5, 0, 0));
      enable = 1'b1;
      wait_done("t5_done");
      check("t5_error", 32'(error), 32'd1);
      repeat (3) @(negedge clock);
      check("t5_error_sticky", 32'(error), 32'd1);
      finish_run();
      check("t5_error_idle", 32'(error), 32'd1);
      push(mk(0, 0, 0));
      push(mk(5, 0, 0));
      enable = 1'b1;
      wait_done("t5b_done");
      check("t5_error_clr", 32'(error), 32'd0);
      finish_run();

      // Reset while in SETTLE
      miso_const = 24'h555555;
      push(mk(1, 20, 24'h777777));
      push(mk(5, 0, 0));
      enable = 1'b1;
      repeat (5) @(negedge clock);
      check("t6_mosi_pre", 32'(mosi), 32'h777777);
      reset_n = 1'b0;
      enable  = 1'b0;
      #1;
      check("t6_done",  32'(done),        32'd0);
      check("t6_rdreq", 32'(sfifo_rdreq), 32'd0);
      check("t6_wrreq", 32'(rfifo_wrreq), 32'd0);
      check("t6_mosi",  32'(mosi),        32'd0);
      check("t6_sel",   32'(target_sel),  32'd0);
      check("t6_rdata", 32'(rfifo_data),  32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      enable = 1'b1;
      wait_done("t6_restart_done");
      check("t6_no_push",    32'(res_cnt), 32'd3);
      check("t6_mosi_after", 32'(mosi),    32'd0);
      check("t6_error",      32'(error),   32'd0);
      finish_run();

      check("no_push_pop_overlap", 32'(overlap), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
